// File: rtl/math_pkg.sv
// math_pkg: shared log2/anti-log fixed-point constants, fraction LUT and result type.
package math_pkg;
  localparam int LOG2_FRAC_W = 6;
  localparam int LOG2_INT_W  = 6;
  typedef logic [LOG2_INT_W+LOG2_FRAC_W-1:0] log2_fix_t;
  // round(64*log2(1+k/64)) for k = 0..63
  localparam logic [LOG2_FRAC_W-1:0] LOG2_LUT [64] = '{
    6'd0,  6'd1,  6'd3,  6'd4,  6'd6,  6'd7,  6'd8,  6'd10,
    6'd11, 6'd12, 6'd13, 6'd15, 6'd16, 6'd17, 6'd18, 6'd19,
    6'd21, 6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28,
    6'd29, 6'd30, 6'd31, 6'd32, 6'd34, 6'd35, 6'd35, 6'd36,
    6'd37, 6'd38, 6'd39, 6'd40, 6'd41, 6'd42, 6'd43, 6'd44,
    6'd45, 6'd46, 6'd47, 6'd47, 6'd48, 6'd49, 6'd50, 6'd51,
    6'd52, 6'd52, 6'd53, 6'd54, 6'd55, 6'd56, 6'd56, 6'd57,
    6'd58, 6'd59, 6'd60, 6'd60, 6'd61, 6'd62, 6'd63, 6'd63
  };
  function automatic logic [LOG2_FRAC_W-1:0] log2_frac(input logic [LOG2_FRAC_W-1:0] k);
    return LOG2_LUT[k];
  endfunction
endpackage

// File: rtl/math_lzd32.sv
// math_lzd32: combinational leading-one detector, position of the highest set bit.
module math_lzd32 (
  input  logic [31:0] data_i,
  output logic [4:0]  pos_o,
  output logic        zero_o
);
  always_comb begin
    pos_o = '0;
    for (int i = 0; i < 32; i++) pos_o = data_i[i] ? 5'(i) : pos_o;
  end
  assign zero_o = ~|data_i;
endmodule

// File: rtl/math_log2_32.sv
// math_log2_32: three-stage pipelined log2 of a 32-bit integer, 6.6 fixed-point
// result, valid/ready handshake with whole-pipeline stall.
module math_log2_32
  import math_pkg::*;
#(
  parameter int LUT_IDX_W = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] dout,
  output logic        dout_zero
);
  logic                 en;
  logic                 s1_v_q;
  logic [31:0]          s1_d_q;
  logic                 s2_v_q, s2_z_q;
  logic [4:0]           s2_p_q;
  logic [LUT_IDX_W-1:0] s2_k_q;
  logic                 s3_v_q, s3_z_q;
  log2_fix_t            s3_dout_q;
  logic [4:0]           p_d;
  logic                 z_d;
  logic [31:0]          norm;
  logic [LUT_IDX_W-1:0] k_d;
  log2_fix_t            dout_d;

  assign en       = !s3_v_q || out_ready;
  assign in_ready = en;

  math_lzd32 u_lzd (.data_i(s1_d_q), .pos_o(p_d), .zero_o(z_d));

  // leading one lands on bit 31; the next LUT_IDX_W bits index the table, the rest truncate
  assign norm   = s1_d_q << (5'd31 - p_d);
  assign k_d    = LUT_IDX_W'(norm >> (31 - LUT_IDX_W));
  assign dout_d = s2_z_q ? '0 : {1'b0, s2_p_q, log2_frac(s2_k_q)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v_q    <= 1'b0;
      s1_d_q    <= '0;
      s2_v_q    <= 1'b0;
      s2_z_q    <= 1'b0;
      s2_p_q    <= '0;
      s2_k_q    <= '0;
      s3_v_q    <= 1'b0;
      s3_z_q    <= 1'b0;
      s3_dout_q <= '0;
    end else if (en) begin
      s1_v_q    <= in_valid;
      s1_d_q    <= din;
      s2_v_q    <= s1_v_q;
      s2_z_q    <= z_d;
      s2_p_q    <= p_d;
      s2_k_q    <= k_d;
      s3_v_q    <= s2_v_q;
      s3_z_q    <= s2_z_q;
      s3_dout_q <= dout_d;
    end
  end

  assign out_valid = s3_v_q;
  assign dout      = s3_dout_q;
  assign dout_zero = s3_z_q;
endmodule

// File: tb/tb_math_log2_32.sv
// tb_math_log2_32: directed vectors plus a real-arithmetic log2 scoreboard for math_log2_32.
module tb_math_log2_32;
  logic        clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] din = '0;
  logic        in_ready, out_valid, dout_zero;
  logic [11:0] dout;
  int          errs = 0, checks = 0;
  logic [12:0] sb [$];
  logic        hold_v = 1'b0;
  logic [12:0] hold_val = '0;
  logic [31:0] sd [64];
  logic [11:0] se [64];
  logic        sz [64];

  always #5 clk = ~clk;

  math_log2_32 dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .dout_zero(dout_zero)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // {zero, dout} from the mathematical definition: integer part = floor(log2 d),
  // fraction = round(64*log2(1+k/64)) with k the truncated 6-bit mantissa
  function automatic logic [12:0] model(input logic [31:0] d);
    int  p = 0;
    int  k, f;
    real m;
    if (d == 0) return 13'h1000;
    for (int i = 0; i < 32; i++) if (64'(d) >= (64'(1) << i)) p = i;
    m = real'(d) / real'(64'(1) << p);
    k = int'($floor((m - 1.0) * 64.0));
    f = int'($floor(64.0 * $ln(1.0 + real'(k) / 64.0) / $ln(2.0) + 0.5));
    return {2'b00, 5'(p), 6'(f)};
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      hold_v = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) chk("unexpected_output", 32'({dout_zero, dout}), 32'hFFFF_FFFF);
        else begin
          chk("model", 32'({dout_zero, dout}), 32'(sb[0]));
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (hold_v) chk("stall_hold", 32'({out_valid, dout_zero, dout}), 32'({1'b1, hold_val}));
      hold_v   = out_valid && !out_ready;
      hold_val = {dout_zero, dout};
      if (in_valid && in_ready) sb.push_back(model(din));
    end
  end

  task automatic step(input logic v, input logic [31:0] d, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    din       = d;
    out_ready = r;
  endtask

  // back-to-back stream; sample j must appear exactly 3 cycles after it was driven
  task automatic run_stream(input int n);
    for (int i = 0; i < n + 3; i++) begin
      step(i < n, i < n ? sd[i] : 32'd0, 1'b1);
      @(negedge clk);
      if (i >= 3)
        chk($sformatf("stream%0d", i - 3), 32'({out_valid, dout_zero, dout}),
            32'({1'b1, sz[i-3], se[i-3]}));
    end
    step(1'b0, 32'd0, 1'b1);
    @(negedge clk);
    chk("stream_end", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0]  bp = 6'b100101;
    logic [31:0] dv [8] = '{32'd1, 32'd2, 32'd3, 32'd5, 32'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    logic [11:0] ev [8] = '{12'h000, 12'h040, 12'h065, 12'h095, 12'h0A5, 12'h7C0, 12'h7FF, 12'h000};
    int          acc, guard;
    chk("pin_model_3", 32'(model(32'd3)), 32'h065);
    chk("pin_model_5", 32'(model(32'd5)), 32'h095);
    chk("pin_model_max", 32'(model(32'hFFFF_FFFF)), 32'h7FF);
    chk("pin_model_zero", 32'(model(32'd0)), 32'h1000);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dout", 32'({dout_zero, dout}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      sd[i] = dv[i];
      se[i] = ev[i];
      sz[i] = (i == 7);
    end
    run_stream(8);

    for (int i = 0; i < 9; i++) begin
      step(i < 6 ? bp[i] : 1'b0, 32'(100 + i), 1'b1);
      @(negedge clk);
      if (i >= 3) chk($sformatf("bubble%0d", i - 3), 32'(out_valid), 32'(bp[i-3]));
    end

    acc   = 0;
    guard = 0;
    while (acc < 10 && guard < 300) begin
      step(1'b1, 32'(1000 * acc + 37 * acc * acc + 7), 1'($urandom % 2));
      @(negedge clk);
      if (in_ready) acc++;
      guard++;
    end
    chk("bp_accepted", 32'(acc), 32'd10);
    for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 1'b1);
    @(negedge clk);
    chk("bp_drained", 32'(sb.size()), 32'd0);

    step(1'b1, 32'd9, 1'b1);
    step(1'b1, 32'd17, 1'b1);
    step(1'b1, 32'd33, 1'b1);
    step(1'b1, 32'd65, 1'b1);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    #2;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_dout", 32'({dout_zero, dout}), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", 32'(out_valid), 32'd0);
    end

    for (int k = 1; k < 32; k++) begin
      sd[2*k-2] = 32'(1) << k;
      se[2*k-2] = {1'b0, 5'(k), 6'd0};
      sz[2*k-2] = 1'b0;
      sd[2*k-1] = (32'(1) << k) | (32'(1) << (k - 1));
      se[2*k-1] = {1'b0, 5'(k), 6'd37};
      sz[2*k-1] = 1'b0;
    end
    run_stream(62);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
